// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, the UART transmitter and the arbiter.
// master = requesters/transmitter side, slave = arbiter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 trmt;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic                 busy;
    logic [2:0]           gnt_id;
    logic                 tmo_err;

    modport master (
        output req, req_data, tx_done,
        input  ack, trmt, tx_data, busy, gnt_id, tmo_err
    );

    modport slave (
        input  req, req_data, tx_done,
        output ack, trmt, tx_data, busy, gnt_id, tmo_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// with trmt/tx_done sequencing, a post-byte idle gap and a stuck-transmitter timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned TMO_CYC = 65536
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_MAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [2:0]         gnt_q, gnt_d;
    logic [7:0]         txd_q, txd_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               trmt_q, trmt_d;
    logic               tmo_q, tmo_d;

    logic               found;
    logic [PW-1:0]      idx;
    logic [PW-1:0]      win;
    logic [7:0]         win_byte;
    logic [NUM_REQ-1:0] win_onehot;

    // Search starts just past the last grant so every source gets a turn.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        win   = ptr_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = PW'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_byte   = '0;
        win_onehot = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (win == PW'(j)) begin
                win_byte      = bus.req_data[8*j +: 8];
                win_onehot[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        txd_d   = txd_q;
        ack_d   = '0;
        trmt_d  = 1'b0;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    ptr_d   = win;
                    gnt_d   = 3'(win);
                    txd_d   = win_byte;
                    ack_d   = win_onehot;
                    trmt_d  = 1'b1;
                end
            end
            SEND: begin
                cnt_d = cnt_q + 1'b1;
                // trmt_q marks the first SEND cycle, where tx_done is not yet meaningful.
                if (bus.tx_done && !trmt_q) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYC > 0) ? GAP : IDLE;
                end else if (cnt_q == CW'(TMO_CYC - 1)) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
            gnt_q   <= '0;
            txd_q   <= '0;
            ack_q   <= '0;
            trmt_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            txd_q   <= txd_d;
            ack_q   <= ack_d;
            trmt_q  <= trmt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.trmt    = trmt_q;
    assign bus.tx_data = txd_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.gnt_id  = gnt_q;
    assign bus.tmo_err = tmo_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: timeline model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned GAP = 2;
    localparam int unsigned TMO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: arbiter is free from cycle idle_from; a byte occupies it from grant until tx_done + GAP.
    int           cyc        = 0;
    int           idle_from  = 0;
    int           send_start = 0;
    bit           sending    = 1'b0;
    int           ptr        = N - 1;
    int           m_gnt      = 0;
    int           w;
    bit           w_found;
    logic [7:0]   m_txd      = '0;
    logic [N-1:0] pend_ack   = '0;
    bit           pend_trmt  = 1'b0;
    bit           pend_tmo   = 1'b0;
    logic [N-1:0] e_ack;
    bit           e_trmt;
    bit           e_tmo;

    always @(negedge clk) begin
        if (!rst_n) begin
            idle_from = cyc;
            sending   = 1'b0;
            ptr       = N - 1;
            m_gnt     = 0;
            m_txd     = '0;
            pend_ack  = '0;
            pend_trmt = 1'b0;
            pend_tmo  = 1'b0;
        end
        e_ack     = pend_ack;
        e_trmt    = pend_trmt;
        e_tmo     = pend_tmo;
        pend_ack  = '0;
        pend_trmt = 1'b0;
        pend_tmo  = 1'b0;
        check("cyc_ack",     32'(bus.ack),     32'(e_ack));
        check("cyc_trmt",    32'(bus.trmt),    32'(e_trmt));
        check("cyc_tx_data", 32'(bus.tx_data), 32'(m_txd));
        check("cyc_busy",    32'(bus.busy),    32'(cyc < idle_from));
        check("cyc_gnt_id",  32'(bus.gnt_id),  32'(m_gnt));
        check("cyc_tmo_err", 32'(bus.tmo_err), 32'(e_tmo));
        if (rst_n) begin
            if (sending && cyc >= send_start + 1 && bus.tx_done) begin
                sending   = 1'b0;
                idle_from = cyc + 1 + int'(GAP);
            end else if (sending && cyc == send_start + int'(TMO) - 1) begin
                sending   = 1'b0;
                pend_tmo  = 1'b1;
                idle_from = cyc + 1;
            end
            if (!sending && cyc >= idle_from && bus.req != '0) begin
                w_found = 1'b0;
                w       = 0;
                for (int k = 1; k <= int'(N); k++) begin
                    if (!w_found && bus.req[(ptr + k) % int'(N)]) begin
                        w_found = 1'b1;
                        w       = (ptr + k) % int'(N);
                    end
                end
                ptr        = w;
                m_gnt      = w;
                m_txd      = bus.req_data[8*w +: 8];
                pend_ack   = N'(1) << w;
                pend_trmt  = 1'b1;
                sending    = 1'b1;
                send_start = cyc + 1;
                idle_from  = 1 << 30;
            end
        end
        cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_trmt(input string tag);
        int k;
        k = 0;
        while (bus.trmt !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check(tag, 32'(bus.trmt), 32'd1);
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    int          exp_id   [5] = '{0, 1, 2, 3, 0};
    logic [7:0]  exp_byte [5] = '{8'h67, 8'h73, 8'hA5, 8'h3C, 8'h67};
    int          tmo_cnt;
    int          tmo_at;

    initial begin
        bus.req      = '0;
        bus.req_data = {8'h3C, 8'hA5, 8'h73, 8'h67};
        bus.tx_done  = 1'b0;
        #1 rst_n = 1'b0;
        tick(2);
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_gnt_id",  32'(bus.gnt_id),  32'd0);

        // Reset in the middle of SEND, then fresh grant of requester 0.
        rst_n   = 1'b1;
        bus.req = 4'b0001;
        wait_trmt("t1_first_trmt");
        tick();
        rst_n = 1'b0;
        #1;
        check("t1_rst_busy",    32'(bus.busy),    32'd0);
        check("t1_rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("t1_rst_trmt",    32'(bus.trmt),    32'd0);
        check("t1_rst_ack",     32'(bus.ack),     32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t1_trmt",    32'(bus.trmt),    32'd1);
        check("t1_ack",     32'(bus.ack),     32'h1);
        check("t1_tx_data", 32'(bus.tx_data), 32'h67);

        // tx_done coincident with trmt must not end SEND.
        bus.req     = '0;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("t5_done_with_trmt_a", 32'(bus.busy), 32'd1);
        tick(3);
        check("t5_done_with_trmt_b", 32'(bus.busy), 32'd1);
        pulse_done();
        tick(3);
        check("t5_back_idle", 32'(bus.busy), 32'd0);

        // tx_done while IDLE is ignored.
        pulse_done();
        check("t5_idle_done_a", 32'(bus.busy), 32'd0);
        tick(2);
        check("t5_idle_done_b", 32'(bus.busy), 32'd0);

        // Round-robin with all four requesting continuously.
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_trmt("t2_trmt");
            check("t2_gnt_id",  32'(bus.gnt_id),  32'(exp_id[i]));
            check("t2_tx_data", 32'(bus.tx_data), 32'(exp_byte[i]));
            check("t2_ack",     32'(bus.ack),     32'(1 << exp_id[i]));
            if (i == 4) bus.req = '0;
            tick();
            pulse_done();
        end
        tick(3);

        // Gap: request during GAP waits until IDLE.
        bus.req = 4'b0001;
        wait_trmt("t3_first_trmt");
        bus.req = '0;
        tick();
        bus.tx_done = 1'b1;
        bus.req     = 4'b0010;
        tick();
        bus.tx_done = 1'b0;
        check("t3_gap1_busy", 32'(bus.busy), 32'd1);
        check("t3_gap1_trmt", 32'(bus.trmt), 32'd0);
        tick();
        check("t3_gap2_busy", 32'(bus.busy), 32'd1);
        check("t3_gap2_ack",  32'(bus.ack),  32'd0);
        tick();
        check("t3_grant_busy", 32'(bus.busy), 32'd0);
        check("t3_grant_trmt", 32'(bus.trmt), 32'd0);
        tick();
        check("t3_trmt", 32'(bus.trmt), 32'd1);
        check("t3_ack",  32'(bus.ack),  32'h2);
        bus.req = '0;
        tick();
        pulse_done();
        tick(3);

        // Request raised and dropped inside GAP is never acked.
        bus.req = 4'b0001;
        wait_trmt("t5c_trmt");
        bus.req = '0;
        tick();
        pulse_done();
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t5c_no_ack",  32'(bus.ack),  32'd0);
            check("t5c_no_busy", 32'(bus.busy), 32'd0);
            tick();
        end

        // Timeout with tx_done held low, then a pending request is served.
        bus.req = 4'b0100;
        wait_trmt("t4_trmt");
        bus.req = 4'b1000;
        tmo_cnt = 0;
        tmo_at  = -1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (bus.tmo_err === 1'b1) begin
                tmo_cnt++;
                tmo_at = k;
            end
            if (k == 8) check("t4_idle_after_tmo", 32'(bus.busy), 32'd0);
        end
        check("t4_tmo_count", 32'(tmo_cnt), 32'd1);
        check("t4_tmo_at",    32'(tmo_at),  32'd8);
        check("t4_next_trmt", 32'(bus.trmt),   32'd1);
        check("t4_next_gnt",  32'(bus.gnt_id), 32'd3);

        // Priority wrap from gnt_id=3 with req=1001.
        bus.req = 4'b1001;
        tick();
        pulse_done();
        wait_trmt("t6_trmt_a");
        check("t6_gnt_a", 32'(bus.gnt_id), 32'd0);
        check("t6_ack_a", 32'(bus.ack),    32'h1);
        tick();
        pulse_done();
        wait_trmt("t6_trmt_b");
        check("t6_gnt_b", 32'(bus.gnt_id), 32'd3);
        check("t6_ack_b", 32'(bus.ack),    32'h8);
        bus.req = '0;
        tick();
        pulse_done();
        tick(4);
        check("end_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
